rr_mux_select_arbiter: RTL and testbench

Two-input round-robin arbiter that sits directly upstream of the `twox1mux` 2:1 multiplexer. It accepts words from two valid/ready sources and decides each cycle which one passes, driving the mux `select`. The chosen word goes through a bank of `twox1mux` instances into a one-entry output register with valid/ready flow control. Alternating grants under contention ensure neither source starves the shared mux path.

---
 rtl/rr_mux_select_arbiter_pkg.sv | 25 ++
 rtl/twox1mux.sv | 15 +
 rtl/rr_mux_select_arbiter.sv | 98 +++++++++
 tb/tb_rr_mux_select_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rr_mux_select_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter.
// Holds the source index constants, the default data width and the
// grant decision helper used by the top-level arbiter.
package rr_mux_select_arbiter_pkg;

  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

  // Chooses the source to grant this cycle. Under contention the source
  // that was not served last wins. With no requester the grant rests on
  // in0, so select idles at 0.
  function automatic logic pickGrant(input logic valid0, input logic valid1,
                                     input logic lastGrant);
    if (valid0 && valid1) begin
      return ~lastGrant;
    end
    if (valid1) begin
      return SRC_IN1;
    end
    return SRC_IN0;
  endfunction

endpackage

// File: rtl/twox1mux.sv
// Single-bit 2:1 multiplexer.
// Ports:
//   in0, in1 - data inputs
//   select   - 0 picks in0, 1 picks in1
//   out      - selected bit
module twox1mux (
  input  logic in0,
  input  logic in1,
  input  logic select,
  output logic out
);

  assign out = select ? in1 : in0;

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// Two-input round-robin arbiter driving the select of a bank of twox1mux
// cells, followed by a one-entry output register with valid/ready flow.
// Ports:
//   clock, reset                    - clock, async active-high reset
//   in0_valid/in0_data/in0_ready    - source 0 valid/ready channel
//   in1_valid/in1_data/in1_ready    - source 1 valid/ready channel
//   select                          - grant driven to the mux bank
//   out_valid/out_data/out_src      - registered output word and its source
//   out_ready                       - downstream accept
module rr_mux_select_arbiter
  import rr_mux_select_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q,  outData_d;
  logic             outSrc_q,   outSrc_d;
  logic             lastGrant_q, lastGrant_d;

  logic             grant;
  logic             loadEn;
  logic             accept;
  logic [WIDTH-1:0] muxOut;

  // The register can take a new word when it is empty or being drained
  // in the same cycle.
  assign loadEn = !outValid_q || out_ready;

  assign grant = pickGrant(in0_valid, in1_valid, lastGrant_q);

  // Select is forced to in0 while reset is held so the mux path is quiet.
  assign select    = reset ? SRC_IN0 : grant;
  assign in0_ready = loadEn && (grant == SRC_IN0) && in0_valid && !reset;
  assign in1_ready = loadEn && (grant == SRC_IN1) && in1_valid && !reset;
  assign accept    = in0_ready || in1_ready;

  // One mux cell per data bit, all steered by the shared select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    twox1mux u_mux (
      .in0    (in0_data[i]),
      .in1    (in1_data[i]),
      .select (select),
      .out    (muxOut[i])
    );
  end

  // Next-state for the output register and the round-robin pointer. The
  // pointer only moves when a word is actually accepted.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outSrc_d    = outSrc_q;
    lastGrant_d = lastGrant_q;
    if (accept) begin
      outValid_d  = 1'b1;
      outData_d   = muxOut;
      outSrc_d    = grant;
      lastGrant_d = grant;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Pointer resets to in1 so that in0 wins the first contention.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outSrc_q    <= SRC_IN0;
      lastGrant_q <= SRC_IN1;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outSrc_q    <= outSrc_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_src   = outSrc_q;

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Self-checking bench for rr_mux_select_arbiter. A stimulus task drives
// inputs mid-cycle, predicts readies and select from a behavioural model
// and pushes accepted words into a scoreboard; a monitor drains the
// scoreboard whenever the output is popped.
module tb_rr_mux_select_arbiter;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in0_valid, in1_valid;
  logic [W-1:0] in0_data, in1_data;
  logic         in0_ready, in1_ready;
  logic         select;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_ready;

  typedef struct packed {
    logic         src;
    logic [W-1:0] data;
  } word_t;

  word_t sb[$];
  int    checks = 0;
  int    passes = 0;
  logic  lastServed;

  rr_mux_select_arbiter #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at posedge+2. Drives one cycle of inputs, checks the handshake
  // signals against the model, then records any accepted word after the
  // edge and returns at the next posedge+2.
  task automatic applyStimulus(input logic v0, input logic [W-1:0] d0,
                               input logic v1, input logic [W-1:0] d1,
                               input logic ordy);
    logic roomForWord;
    logic winner;
    logic expR0, expR1;
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
    #1;
    roomForWord = (sb.size() == 0) || ordy;
    // Lone requester wins; two requesters alternate away from the last
    // served source; idle rests on source 0.
    if (v0 && v1) winner = !lastServed;
    else          winner = v1;
    expR0 = roomForWord && v0 && (winner == 1'b0);
    expR1 = roomForWord && v1 && (winner == 1'b1);
    checkOutput("in0_ready", 32'(in0_ready), 32'(expR0));
    checkOutput("in1_ready", 32'(in1_ready), 32'(expR1));
    checkOutput("select", 32'(select), 32'(winner));
    checkOutput("both_ready", 32'(in0_ready && in1_ready), 32'(0));
    @(posedge clock);
    if (expR0 || expR1) begin
      sb.push_back('{src: winner, data: (winner ? d1 : d0)});
      lastServed = winner;
    end
    #2;
  endtask

  // Monitor: mid-cycle, compare the output register to the scoreboard head
  // and retire the head when downstream takes it at the coming edge.
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0 && out_ready) begin
        word_t expWord;
        expWord = sb.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(expWord.data));
        checkOutput("out_src", 32'(out_src), 32'(expWord.src));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    in0_valid  = 1'b1;
    in1_valid  = 1'b1;
    in0_data   = 8'h12;
    in1_data   = 8'h34;
    out_ready  = 1'b1;
    lastServed = 1'b1;

    // Requests are present during reset, yet nothing may be accepted.
    repeat (2) @(posedge clock);
    #2;
    checkOutput("rst_in0_ready", 32'(in0_ready), 32'(0));
    checkOutput("rst_in1_ready", 32'(in1_ready), 32'(0));
    checkOutput("rst_select", 32'(select), 32'(0));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_data", 32'(out_data), 32'(0));
    checkOutput("rst_out_src", 32'(out_src), 32'(0));
    reset = 1'b0;

    // Single source after reset.
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Contention fairness.
    repeat (6) applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Backpressure, then release with back-to-back pop and load.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C, 1'b1);
    repeat (4) applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h7E, 1'b1);

    // Reset pulse in the middle of a stall.
    applyStimulus(1'b1, 8'h09, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'(0));
    checkOutput("async_out_data", 32'(out_data), 32'(0));
    sb.delete();
    lastServed = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 3) != 0));
    end

    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("sb_drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
